// File: rtl/sine_wave_dds.sv
// sine_wave_dds: multi-channel phase-accumulator sine generator using a
// quarter-wave ROM, with a valid/ready (stream-style) sample-set output.
// Optional macro SINE_WAVE_DDS_AMP_EN adds a per-channel amplitude stage.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   en, sync          : sample enable, synchronous accumulator clear
//   cfg_we/ch/addr/wdata : config write (0 inc, 1 offset, 2 amp, 3 rsvd)
//   m_tdata/m_tvalid/m_tready : sample-set output handshake
module sine_wave_dds #(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 16,
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 10,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     sync,
  input  logic                     cfg_we,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [1:0]               cfg_addr,
  input  logic [PHASE_W-1:0]       cfg_wdata,
  output logic [NUM_CH*DATA_W-1:0] m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready
);

  localparam int ROM_N = 2 ** LUT_AW;
  localparam int PW    = LUT_AW + 2;
  localparam int TR    = PHASE_W - PW;

  function automatic int rom_val(input int k);
    real a;
    a = (2.0 ** (DATA_W - 1)) - 1.0;
    return $rtoi(a * $sin(3.14159265358979 * k / (2.0 * ROM_N)) + 0.5);
  endfunction

  // Quarter-wave table, includes the endpoint so q1/q3 mirror cleanly.
  logic [DATA_W-1:0] rom [ROM_N+1];
  for (genvar k = 0; k <= ROM_N; k++) begin : g_rom
    localparam int V = rom_val(k);
    assign rom[k] = DATA_W'(V);
  end

  logic                     adv;
  logic                     issue;
  logic [PHASE_W-1:0]       acc_q  [NUM_CH];
  logic [PHASE_W-1:0]       acc_d  [NUM_CH];
  logic [PHASE_W-1:0]       ph_d   [NUM_CH];
  logic [PHASE_W-1:0]       inc_q  [NUM_CH];
  logic [PHASE_W-1:0]       off_q  [NUM_CH];
  logic [PW-1:0]            ph_q   [NUM_CH];
  logic [LUT_AW:0]          ra     [NUM_CH];
  logic [DATA_W-1:0]        mag_q  [NUM_CH];
  logic [NUM_CH-1:0]        neg_q;
  logic [NUM_CH*DATA_W-1:0] smp_q;
  logic                     v1_q;
  logic                     v2_q;
  logic                     v3_q;

  assign adv   = m_tready | ~m_tvalid;
  assign issue = adv & en & ~sync;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ph_d[c]  = acc_q[c] + off_q[c];
      acc_d[c] = acc_q[c];
      if (sync) begin
        acc_d[c] = '0;
      end else if (adv && en) begin
        acc_d[c] = acc_q[c] + inc_q[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        inc_q[c] <= '0;
        off_q[c] <= '0;
      end
    end else if (cfg_we) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg_ch == CH_W'(c)) begin
          if (cfg_addr == 2'd0) inc_q[c] <= cfg_wdata;
          if (cfg_addr == 2'd1) off_q[c] <= cfg_wdata;
        end
      end
    end
  end

  // Stage 1: issue phase; only quadrant + index bits are kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
        ph_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= acc_d[c];
      end
      if (adv) begin
        v1_q <= issue;
        for (int c = 0; c < NUM_CH; c++) begin
          ph_q[c] <= PW'(ph_d[c] >> TR);
        end
      end
    end
  end

  // Odd quadrants read the table backwards.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ra[c] = {1'b0, ph_q[c][LUT_AW-1:0]};
      if (ph_q[c][LUT_AW]) begin
        ra[c] = (LUT_AW+1)'(ROM_N) - {1'b0, ph_q[c][LUT_AW-1:0]};
      end
    end
  end

  // Stage 2: ROM read; stage 3: apply sign for the lower half-wave.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      neg_q <= '0;
      smp_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        mag_q[c] <= '0;
      end
    end else if (adv) begin
      v2_q <= v1_q;
      v3_q <= v2_q;
      for (int c = 0; c < NUM_CH; c++) begin
        mag_q[c] <= rom[ra[c]];
        neg_q[c] <= ph_q[c][PW-1];
        smp_q[c*DATA_W +: DATA_W] <= neg_q[c] ? -mag_q[c] : mag_q[c];
      end
    end
  end

`ifdef SINE_WAVE_DDS_AMP_EN
  localparam int PR = 2 * DATA_W + 1;
  localparam logic [DATA_W-1:0] UNITY = DATA_W'(2 ** (DATA_W - 1));

  logic [DATA_W-1:0]        amp_q [NUM_CH];
  logic [DATA_W-1:0]        amp_e [NUM_CH];
  logic signed [PR-1:0]     prod  [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] out_q;
  logic                     v4_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        amp_q[c] <= UNITY;
      end
    end else if (cfg_we && cfg_addr == 2'd2) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg_ch == CH_W'(c)) amp_q[c] <= cfg_wdata[DATA_W-1:0];
      end
    end
  end

  // amp is unsigned Q1.(DATA_W-1); anything above 1.0 clamps to 1.0.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      amp_e[c] = (amp_q[c] > UNITY) ? UNITY : amp_q[c];
      prod[c]  = PR'($signed(smp_q[c*DATA_W +: DATA_W]))
               * PR'($signed({1'b0, amp_e[c]}));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v4_q  <= 1'b0;
      out_q <= '0;
    end else if (adv) begin
      v4_q <= v3_q;
      for (int c = 0; c < NUM_CH; c++) begin
        out_q[c*DATA_W +: DATA_W] <= DATA_W'(prod[c] >>> (DATA_W - 1));
      end
    end
  end

  assign m_tdata  = out_q;
  assign m_tvalid = v4_q;
`else
  assign m_tdata  = smp_q;
  assign m_tvalid = v3_q;
`endif

endmodule

// File: tb/tb_sine_wave_dds.sv
// tb_sine_wave_dds: scoreboard bench for sine_wave_dds (3 channels).
// Stimulus pushes hand-computed sample sets; a monitor pops on handshake.
module tb_sine_wave_dds;

`ifdef SINE_WAVE_DDS_AMP_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        sync;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [47:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;

  int          checks = 0;
  int          errors = 0;
  int          n = 0;
  bit          half0 = 1'b0;
  logic [47:0] sb [$];

  sine_wave_dds #(.NUM_CH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sync      (sync),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready)
  );

  always #5 clk = ~clk;

  // ch0: inc 2^30 off 0; ch1: inc 2^30 off 2^30; ch2: inc 2^31 off 2^30
  function automatic logic [47:0] exp_word(input int k, input bit half);
    logic [15:0] c0, c1, c2;
    c0 = 16'h0000;
    c1 = 16'h0000;
    case (k % 4)
      0: c1 = 16'h7FFF;
      1: c0 = half ? 16'h3FFF : 16'h7FFF;
      2: c1 = 16'h8001;
      default: c0 = half ? 16'hC000 : 16'h8001;
    endcase
    c2 = (k % 2 == 0) ? 16'h7FFF : 16'h8001;
    return {c2, c1, c0};
  endfunction

  task automatic chk(input string nm, input logic [47:0] act,
                     input logic [47:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic push_exp();
    sb.push_back(exp_word(n, half0));
    n++;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [1:0] a,
                           input logic [31:0] d);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_ch = ch; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic config_all();
    cfg_write(2'd0, 2'd0, 32'h4000_0000);
    cfg_write(2'd1, 2'd0, 32'h4000_0000);
    cfg_write(2'd1, 2'd1, 32'h4000_0000);
    cfg_write(2'd2, 2'd0, 32'h8000_0000);
    cfg_write(2'd2, 2'd1, 32'h4000_0000);
    cfg_write(2'd3, 2'd0, 32'h1234_5678);
    cfg_write(2'd3, 2'd1, 32'h0000_0001);
    cfg_write(2'd0, 2'd3, 32'hFFFF_FFFF);
  endtask

  // Leaves en=1 with one more issue pending at the next edge.
  task automatic start_stream(input int cnt);
    en = 1'b1; m_tready = 1'b1;
    push_exp();
    for (int c = 1; c < cnt; c++) begin
      @(posedge clk); #1;
      if (c <= LAT) chk("latency", 48'(m_tvalid), 48'(c == LAT));
      push_exp();
    end
  endtask

  task automatic stop();
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic drain();
    en = 1'b0; m_tready = 1'b1;
    repeat (LAT + 3) @(posedge clk);
    #1;
    chk("drain_empty", 48'(sb.size()), 48'd0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && m_tvalid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_sample: got %h expected none", m_tdata);
        end else begin
          if (m_tdata !== sb[0]) begin
            errors++;
            $display("FAIL sample: got %h expected %h", m_tdata, sb[0]);
          end
          if (m_tready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; sync = 1'b0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_addr = '0; cfg_wdata = '0; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 48'(m_tvalid), 48'd0);
    chk("rst_tdata", m_tdata, 48'd0);
    rst_n = 1'b1;
    config_all();

    start_stream(13);
    @(posedge clk); #1;
    m_tready = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("stall_valid", 48'(m_tvalid), 48'd1);
    m_tready = 1'b1;
    push_exp();
    repeat (5) begin
      @(posedge clk); #1;
      push_exp();
    end

    @(posedge clk); #1;
    sync = 1'b1;
    @(posedge clk); #1;
    sync = 1'b0;
    n = 0;
    push_exp();
    repeat (7) begin
      @(posedge clk); #1;
      push_exp();
    end
    stop();
    drain();

`ifdef SINE_WAVE_DDS_AMP_EN
    cfg_write(2'd0, 2'd2, 32'h0000_4000);
    half0 = 1'b1;
    start_stream(6);
    stop();
    drain();
    cfg_write(2'd0, 2'd2, 32'h0000_FFFF);
    half0 = 1'b0;
    start_stream(6);
    stop();
    drain();
`endif

    start_stream(6);
    chk("pre_rst_valid", 48'(m_tvalid), 48'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", 48'(m_tvalid), 48'd0);
    chk("mid_rst_tdata", m_tdata, 48'd0);
    sb.delete();
    en = 1'b0; n = 0; half0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    config_all();
    start_stream(8);
    stop();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
